// File: rtl/layer_requant_bridge.sv
// layer_requant_bridge: round/shift/saturate eight int16 lanes to int8 and buffer them in a FIFO.
// Define LAYER_REQUANT_SATCNT_EN to add the sat_count output.
module layer_requant_bridge #(
  parameter int SHIFT = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_in,
  input  logic [15:0]              y0,
  input  logic [15:0]              y1,
  input  logic [15:0]              y2,
  input  logic [15:0]              y3,
  input  logic [15:0]              y4,
  input  logic [15:0]              y5,
  input  logic [15:0]              y6,
  input  logic [15:0]              y7,
  output logic [7:0]               x0,
  output logic [7:0]               x1,
  output logic [7:0]               x2,
  output logic [7:0]               x3,
  output logic [7:0]               x4,
  output logic [7:0]               x5,
  output logic [7:0]               x6,
  output logic [7:0]               x7,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
`ifdef LAYER_REQUANT_SATCNT_EN
  ,
  output logic [15:0]              sat_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic signed [16:0] RND = (17'sd1 <<< SHIFT) >>> 1;
  localparam logic signed [16:0] QMAX = 17'sd127;
  localparam logic signed [16:0] QMIN = -17'sd128;
  logic [15:0] y [8];
  logic [7:0] q_c [8];
  logic [7:0] sat_c;
  assign y = '{y0, y1, y2, y3, y4, y5, y6, y7};
  genvar i;
  for (i = 0; i < 8; i++) begin : g_lane
    logic signed [16:0] t, s;
    assign t = $signed({y[i][15], y[i]}) + RND;
    assign s = t >>> SHIFT;
    assign sat_c[i] = (s > QMAX) || (s < QMIN);
    assign q_c[i] = s > QMAX ? 8'h7f : s < QMIN ? 8'h80 : s[7:0];
  end
  logic [63:0] q1;
  logic        s1_valid;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      q1 <= '0;
    end else begin
      s1_valid <= valid_in;
      if (valid_in) q1 <= {q_c[7], q_c[6], q_c[5], q_c[4], q_c[3], q_c[2], q_c[1], q_c[0]};
    end
  end
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, pop, push;
  assign full = count == FULL;
  assign valid_out = |count;
  assign pop = valid_out & ready_in;
  // a pop on the same edge frees the slot, so a full FIFO still accepts the push
  assign push = s1_valid & (~full | pop);
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= q1;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      overflow <= overflow | (s1_valid & full & ~pop);
    end
  end
  assign {x7, x6, x5, x4, x3, x2, x1, x0} = valid_out ? mem[rd_ptr] : 64'd0;
`ifdef LAYER_REQUANT_SATCNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sat_count <= '0;
    else if (valid_in && |sat_c && sat_count != 16'hffff) sat_count <= sat_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_layer_requant_bridge.sv
// tb_layer_requant_bridge: directed checks of requantization, FIFO fill/drain, stall, wrap and reset.
module tb_layer_requant_bridge;
  logic        clk, reset, valid_in, ready_in, valid_out, overflow;
  logic [15:0] y0, y1, y2, y3, y4, y5, y6, y7;
  logic [7:0]  x0, x1, x2, x3, x4, x5, x6, x7;
  logic [2:0]  count;
  logic [63:0] xv;
  int          n_cmp = 0;
  int          n_err = 0;
`ifdef LAYER_REQUANT_SATCNT_EN
  logic [15:0] sat_count;
`endif
  layer_requant_bridge #(.SHIFT(4), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5), .y6(y6), .y7(y7),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5), .x6(x6), .x7(x7),
    .valid_out(valid_out), .ready_in(ready_in), .count(count), .overflow(overflow)
`ifdef LAYER_REQUANT_SATCNT_EN
    , .sat_count(sat_count)
`endif
  );
  assign xv = {x7, x6, x5, x4, x3, x2, x1, x0};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7);
    return {a7[7:0], a6[7:0], a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction
  task automatic set_y(input int v0, v1, v2, v3, v4, v5, v6, v7);
    y0 = v0[15:0]; y1 = v1[15:0]; y2 = v2[15:0]; y3 = v3[15:0];
    y4 = v4[15:0]; y5 = v5[15:0]; y6 = v6[15:0]; y7 = v7[15:0];
  endtask
  initial begin
    reset = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
    set_y(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_x", xv, 64'd0);
`ifdef LAYER_REQUANT_SATCNT_EN
    chk("rst_satcnt", 64'(sat_count), 64'd0);
`endif
    reset = 1'b1;
    tick;
    // rounding
    ready_in = 1'b1;
    set_y(256, 24, -8, -9, 7, 8, 0, -24);
    valid_in = 1'b1; tick; valid_in = 1'b0;
    chk("t1_latency", 64'(valid_out), 64'd0);
    tick;
    chk("t1_valid", 64'(valid_out), 64'd1);
    chk("t1_x", xv, pk(16, 2, 0, -1, 0, 1, 0, -1));
    tick;
    chk("t1_drain", 64'(count), 64'd0);
    // saturation
    set_y(2047, -3000, 32767, -32768, 0, 0, 0, 0);
    valid_in = 1'b1; tick; valid_in = 1'b0;
`ifdef LAYER_REQUANT_SATCNT_EN
    chk("t2_satcnt", 64'(sat_count), 64'd1);
`endif
    tick;
    chk("t2_x", xv, pk(127, -128, 127, -128, 0, 0, 0, 0));
    tick;
    // fill and overflow
    ready_in = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      set_y(16 * k, 0, 0, 0, 0, 0, 0, 0);
      valid_in = 1'b1; tick;
    end
    valid_in = 1'b0; tick;
    chk("t3_count", 64'(count), 64'd4);
    chk("t3_ovf", 64'(overflow), 64'd1);
    chk("t3_head", 64'(x0), 64'd1);
    ready_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("t3_pop", 64'(x0), 64'(k));
      tick;
    end
    chk("t3_empty_count", 64'(count), 64'd0);
    chk("t3_empty_valid", 64'(valid_out), 64'd0);
    // full push+pop
    reset = 1'b0; #2;
    chk("t4_rst_ovf", 64'(overflow), 64'd0);
    reset = 1'b1; tick;
    ready_in = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      set_y(16 * k, 0, 0, 0, 0, 0, 0, 0);
      valid_in = 1'b1; tick;
    end
    valid_in = 1'b0; tick;
    chk("t4_full", 64'(count), 64'd4);
    set_y(144, 0, 0, 0, 0, 0, 0, 0);
    valid_in = 1'b1; tick; valid_in = 1'b0;
    ready_in = 1'b1; tick;
    chk("t4_count", 64'(count), 64'd4);
    chk("t4_ovf", 64'(overflow), 64'd0);
    for (int k = 2; k <= 4; k++) begin
      chk("t4_order", 64'(x0), 64'(k));
      tick;
    end
    chk("t4_tail", 64'(x0), 64'd9);
    tick;
    chk("t4_drain", 64'(count), 64'd0);
    // stall
    ready_in = 1'b0;
    set_y(256, 24, -8, -9, 7, 8, 0, -24);
    valid_in = 1'b1; tick; valid_in = 1'b0; tick;
    for (int c = 0; c < 10; c++) begin
      chk("t5_stall_x", xv, pk(16, 2, 0, -1, 0, 1, 0, -1));
      chk("t5_stall_count", 64'(count), 64'd1);
      tick;
    end
    ready_in = 1'b1; tick;
    chk("t5_stall_pop", 64'(count), 64'd0);
    // pointer wrap with streaming push/pop
    for (int k = 1; k <= 10; k++) begin
      set_y(16 * k, 0, 0, 0, 0, 0, 0, 0);
      valid_in = 1'b1; tick;
      if (k >= 2) begin
        chk("t5_wrap_x0", 64'(x0), 64'(k - 1));
        chk("t5_wrap_count", 64'(count), 64'd1);
      end
    end
    valid_in = 1'b0; tick;
    chk("t5_wrap_last", 64'(x0), 64'd10);
    tick;
    chk("t5_wrap_empty", 64'(count), 64'd0);
    // reset mid-stream
    ready_in = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      set_y(16 * k, 0, 0, 0, 0, 0, 0, 0);
      valid_in = 1'b1; tick;
    end
    valid_in = 1'b0;
    chk("t6_pre_count", 64'(count), 64'd3);
    #2; reset = 1'b0; #1;
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_valid", 64'(valid_out), 64'd0);
    chk("t6_ovf", 64'(overflow), 64'd0);
    chk("t6_x", xv, 64'd0);
    #2; reset = 1'b1;
    tick; tick;
    chk("t6_post_count", 64'(count), 64'd0);
    chk("t6_post_valid", 64'(valid_out), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
